// File: rtl/pipe_pkg.sv
// Shared pipeline types: skid-stage state encoding and per-stage payload bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // MEM -> WB payload; its width sets DATA_W for that stage instance.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic        wb_en;
    logic [1:0]  wb_sel;
  } mem_wb_t;

  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter.
// Ports: clk, rst_n (async active-low), inc (count enable), cnt (value, holds at all-ones).
module pipe_perf_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with one-entry skid buffer and synchronous flush.
// Ports: clk, rst_n (async active-low), flush, in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream); with PIPE_SKID_PERF_EN also
//        stall_cnt and bubble_cnt saturating performance counters.
// in_ready and out_valid come straight from the state register.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_WB_W
`ifdef PIPE_SKID_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              acc;
  logic              fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;

  assign acc  = in_valid & in_ready;
  assign fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Squash: valid state clears, data registers keep their contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_d = in_data;
          end else if (acc) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid),
    .cnt   (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned DW = 16;
`ifdef PIPE_SKID_PERF_EN
  localparam int unsigned CW = 4;
`endif

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  pipe_stage_skid #(
    .DATA_W (DW)
`ifdef PIPE_SKID_PERF_EN
    , .CNT_W (CW)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef PIPE_SKID_PERF_EN
    , .stall_cnt  (stall_cnt)
    , .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic          e_ir;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] q[$];
    int unsigned   n_out_model;
    int unsigned   n_out_dut;
    logic          m_acc;
    logic          m_fire;

    //             fl    iv    data      ordy  e_ov  e_ir  e_od
    tbl[0]  = '{1'b0, 1'b1, 16'h00A1, 1'b1, 1'b1, 1'b1, 16'h00A1};
    tbl[1]  = '{1'b0, 1'b1, 16'h00B2, 1'b0, 1'b1, 1'b0, 16'h00A1};
    tbl[2]  = '{1'b0, 1'b1, 16'h00C3, 1'b0, 1'b1, 1'b0, 16'h00A1};
    tbl[3]  = '{1'b0, 1'b1, 16'h00C3, 1'b0, 1'b1, 1'b0, 16'h00A1};
    tbl[4]  = '{1'b0, 1'b1, 16'h00C3, 1'b1, 1'b1, 1'b1, 16'h00B2};
    tbl[5]  = '{1'b0, 1'b1, 16'h00C3, 1'b1, 1'b1, 1'b1, 16'h00C3};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00C3};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00C3};
    tbl[8]  = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 16'h0011};
    tbl[9]  = '{1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 16'h0011};
    tbl[10] = '{1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0011};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0011};
    tbl[12] = '{1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 1'b1, 16'h0033};
    tbl[13] = '{1'b1, 1'b1, 16'h0044, 1'b1, 1'b0, 1'b1, 16'h0033};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0033};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_data",  64'(out_data),  64'd0);

    // Back-pressure and flush vectors.
    for (int i = 0; i < 15; i++) begin
      flush = tbl[i].fl; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      step();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d_in_ready",  i), 64'(in_ready),  64'(tbl[i].e_ir));
      check($sformatf("vec%0d_out_data",  i), 64'(out_data),  64'(tbl[i].e_od));
    end
    flush = 1'b0;

    // Asynchronous reset while FULL, no clock edge needed.
    in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b0; step();
    in_data = 16'h0066; step();
    check("prereset_full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_out_data",  64'(out_data),  64'd0);
    check("async_reset_in_ready",  64'(in_ready),  64'd1);
`ifdef PIPE_SKID_PERF_EN
    check("async_reset_stall_cnt",  64'(stall_cnt),  64'd0);
    check("async_reset_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;

    // Streaming 0x01..0x10 at full throughput.
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; in_data = DW'(k);
      step();
      check($sformatf("stream%0d_out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d_out_data",  k), 64'(out_data),  64'(k));
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_out_valid", 64'(out_valid), 64'd0);

`ifdef PIPE_SKID_PERF_EN
    // 7 bubble cycles then 5 stall cycles, then saturation at 15.
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    repeat (6) step();
    in_valid = 1'b1; in_data = 16'h0077;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("perf_stall_cnt",  64'(stall_cnt),  64'd5);
    check("perf_bubble_cnt", 64'(bubble_cnt), 64'd7);
    flush = 1'b1; step(); flush = 1'b0;
    repeat (20) step();
    check("perf_stall_cnt_flush_unaffected", 64'(stall_cnt), 64'd6);
    check("perf_bubble_cnt_after_flush", 64'(bubble_cnt), 64'd15);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (20) step();
    check("perf_stall_sat",  64'(stall_cnt),  64'd15);
    check("perf_bubble_sat", 64'(bubble_cnt), 64'd15);
`endif

    // Random valid/ready/flush against a 2-deep FIFO occupancy model.
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    q.delete();
    n_out_model = 0;
    n_out_dut   = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rand_out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("rand_in_ready",  64'(in_ready),  64'(q.size() < 2));
      if (q.size() > 0) check("rand_out_data", 64'(out_data), 64'(q[0]));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 31) == 0);
      m_acc  = in_valid && (q.size() < 2);
      m_fire = (q.size() > 0) && out_ready;
      if (m_fire) n_out_model++;
      if (out_valid && out_ready) n_out_dut++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_fire) void'(q.pop_front());
        if (m_acc) q.push_back(in_data);
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
    check("rand_delivered_count", 64'(n_out_dut), 64'(n_out_model));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
